// File: rtl/rect_plotter.sv
// Rectangle rasteriser: latches one rectangle request and streams it to the VGA
// adapter as one pixel per clock, clipping pixels outside the 160x120 frame.
module rect_plotter #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned SZ_W     = 4,
    parameter int unsigned COL_W    = 3,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [SZ_W-1:0]  w,
    input  logic [SZ_W-1:0]  h,
    input  logic [COL_W-1:0] colour_in,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    // Sums carry one extra bit so off-screen coordinates clip instead of wrapping.
    localparam int unsigned XS_W = X_W + 1;
    localparam int unsigned YS_W = Y_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [X_W-1:0]     x0_q;
    logic [Y_W-1:0]     y0_q;
    logic [SZ_W-1:0]    w_q;
    logic [SZ_W-1:0]    h_q;
    logic [COL_W-1:0]   col_q;
    logic [SZ_W-1:0]    cx;
    logic [SZ_W-1:0]    cy;

    logic               col_end;
    logic               row_end;
    logic [SZ_W-1:0]    nxt_cx;
    logic [SZ_W-1:0]    nxt_cy;
    logic [XS_W-1:0]    draw_x;
    logic [YS_W-1:0]    draw_y;
    logic [XS_W-1:0]    first_x;
    logic [YS_W-1:0]    first_y;
    logic               size_zero;

    // Next scan position and the pixel it maps to, so outputs can be registered.
    always_comb begin
        col_end   = (cx == w_q - SZ_W'(1));
        row_end   = (cy == h_q - SZ_W'(1));
        nxt_cx    = col_end ? '0 : cx + SZ_W'(1);
        nxt_cy    = col_end ? cy + SZ_W'(1) : cy;
        draw_x    = XS_W'(x0_q) + XS_W'(nxt_cx);
        draw_y    = YS_W'(y0_q) + YS_W'(nxt_cy);
        first_x   = XS_W'(x0);
        first_y   = YS_W'(y0);
        size_zero = (w == '0) || (h == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            x0_q   <= '0;
            y0_q   <= '0;
            w_q    <= '0;
            h_q    <= '0;
            col_q  <= '0;
            cx     <= '0;
            cy     <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        x0_q   <= x0;
                        y0_q   <= y0;
                        w_q    <= w;
                        h_q    <= h;
                        col_q  <= colour_in;
                        colour <= colour_in;
                        cx     <= '0;
                        cy     <= '0;
                        busy   <= 1'b1;
                        if (size_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // First pixel is presented in the cycle right after the request.
                            state <= DRAW;
                            x     <= x0;
                            y     <= y0;
                            plot  <= (first_x < XS_W'(SCREEN_W)) &&
                                     (first_y < YS_W'(SCREEN_H));
                        end
                    end
                end
                DRAW: begin
                    busy   <= 1'b1;
                    colour <= col_q;
                    if (col_end && row_end) begin
                        state <= DONE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cx   <= nxt_cx;
                        cy   <= nxt_cy;
                        x    <= draw_x[X_W-1:0];
                        y    <= draw_y[Y_W-1:0];
                        plot <= (draw_x < XS_W'(SCREEN_W)) &&
                                (draw_y < YS_W'(SCREEN_H));
                        done <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    plot  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    plot  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
